nco_mc_monitor: RTL and testbench
=================================

Name: nco_mc_monitor

Overview:
- Synthesisable, parametrised successor to the NCO protocol assertions.
- Watches NUM_CH NCO channels, each with a select bus and a wave bus, and applies three checks per channel:
  - post-reset wave-zero check;
  - select hold-window check;
  - wave response-latency check.
- Records violations in per-channel sticky flags and saturating counters, with one interrupt line.
- Sits beside the NCO array in both silicon and the testbench. The same errors are therefore visible to firmware and to the scoreboard.

Parameters:
- NUM_CH, 4, number of monitored channels.
- SELECT_WIDTH, 3, width of each channel's select bus.
- WAVE_WIDTH, 8, width of each channel's wave sample.
- HOLD_CYCLES, 32, minimum number of cycles a select value must persist, counting the change cycle. Must be 2 or more.
- RESP_LATENCY, 1, cycles from a select change to the required wave change. Must be 1 or more.
- CNT_WIDTH, 8, width of each per-channel error counter.

Ports:
- clk  in  1  monitor clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- signal_out  in  NUM_CH*SELECT_WIDTH  packed per-channel select values; channel i occupies bits [i*SELECT_WIDTH +: SELECT_WIDTH].
- wave_out  in  NUM_CH*WAVE_WIDTH  packed per-channel wave samples.
- clear_i  in  1  synchronous clear of all flags and counters.
- err_flags_o  out  NUM_CH*3  per-channel sticky flags {RESP,HOLD,RST}; bit 0 = RST.
- err_cnt_o  out  NUM_CH*CNT_WIDTH  per-channel saturating error counts.
- irq_o  out  1  OR of all err_flags_o bits, registered.

Behaviour:
- Reset:
  - Asynchronous, active-low, single clock: resetn low immediately clears all state.
  - Every output resets to 0. Every channel FSM resets to INIT. Pending response pipelines, hold counters and previous-sample registers reset to 0.
  - Reset mid-operation discards all in-flight checks.
- Per-channel FSM states: INIT, IDLE, HOLD.
  - INIT occupies exactly the first rising edge after resetn rises.
    - Capture sel_prev and wave_prev.
    - If the wave sample is not 0, raise RST.
    - No change detection is done in this state.
    - Always go to IDLE.
  - sel_chg = (select != sel_prev). sel_prev and wave_prev update on every edge outside reset.
  - IDLE:
    - On sel_chg, load hold_cnt = HOLD_CYCLES-1, go to HOLD, and push a pending token into the response pipeline.
  - HOLD:
    - hold_cnt decrements each edge.
    - If sel_chg while hold_cnt != 0: raise HOLD, reload hold_cnt = HOLD_CYCLES-1, stay in HOLD, and push a token.
    - When hold_cnt reaches 0 with no change, go to IDLE.
    - With defaults, a change exactly 32 edges after the previous change is legal; a change at 31 edges is an error.
- Response check:
  - Shift register of depth RESP_LATENCY carries the tokens.
  - When a token exits, if wave == wave_prev, raise RESP.
  - Tokens from back-to-back changes are checked independently.
- Flag and counter update timing:
  - Flags set on the edge that samples the violation and are visible the following cycle.
  - irq_o follows one cycle after the flags.
  - Counter adds +1 per edge on which any flag type is raised for that channel, even if several are raised together.
  - Counter saturates at 2^CNT_WIDTH-1 and never wraps.
- clear_i:
  - Zeroes all flags and counters on that edge.
  - If a violation is raised on the same edge, the violation wins: that flag is set and the counter is 1.
  - clear_i does not affect FSMs or pipelines.
- Widths and encodings:
  - hold_cnt width is $clog2(HOLD_CYCLES).
  - All comparisons are unsigned equality.
  - X on inputs is not handled in RTL. The bench asserts inputs are known outside reset.

Decomposition:
- Package nco_mon_pkg holds:
  - the state enum (INIT, IDLE, HOLD);
  - flag bit indices ERR_RST=0, ERR_HOLD=1, ERR_RESP=2;
  - ERR_W=3.
- Sub-module nco_ch_checker: one channel's FSM, hold counter, response pipeline, flags and counter.
- The top module generates NUM_CH instances and the irq OR-reduction register.

Test Plan:
1. Release reset with ch0 wave=0x00 and ch1 wave=0x5A -> ch1 RST flag=1 and err_cnt ch1=1; irq_o=1 one cycle later; ch0/2/3 flags=0.
2. ch0 select 0->2 at edge t, wave changes at t+1, select held, next change at t+32, wave changes at t+33 -> no flags, counts remain 0.
3. ch2 select change at t, then again at t+10 -> HOLD flag ch2 visible after edge t+10, count=1; a further change at t+20 -> count=2.
4. ch3 select change with wave held constant, RESP_LATENCY=1; rerun with RESP_LATENCY=3 and wave changing at t+1 only -> RESP flag raised at t+1 and at t+3 respectively.
5. Force 300 HOLD violations on ch1 -> err_cnt ch1 saturates at 255; then clear_i together with a new violation -> flag HOLD=1, count=1.
6. Assert resetn low mid-HOLD with a token pending -> all outputs 0 immediately; after release, a select differing from the pre-reset value -> no HOLD or RESP flag on the INIT edge.

Source files
------------

// File: rtl/nco_mon_pkg.sv
// Shared types and flag encodings for the multi-channel NCO protocol monitor.
package nco_mon_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        HOLD
    } ch_state_e;

    localparam int ERR_RST  = 0;
    localparam int ERR_HOLD = 1;
    localparam int ERR_RESP = 2;
    localparam int ERR_W    = 3;

endpackage

// File: rtl/nco_ch_checker.sv
// One NCO channel: post-reset wave check, select hold-window check and
// select-to-wave response check, feeding sticky flags and a saturating count.
module nco_ch_checker
    import nco_mon_pkg::*;
#(
    parameter int SELECT_WIDTH = 3,
    parameter int WAVE_WIDTH   = 8,
    parameter int HOLD_CYCLES  = 32,
    parameter int RESP_LATENCY = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SELECT_WIDTH-1:0] i_sel,
    input  logic [WAVE_WIDTH-1:0]   i_wave,
    input  logic                    i_clear,
    output logic [ERR_W-1:0]        o_flags,
    output logic [CNT_WIDTH-1:0]    o_cnt
);

    localparam int               HC_W        = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0]  HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);

    ch_state_e               r_state;
    logic [SELECT_WIDTH-1:0] r_sel_prev;
    logic [WAVE_WIDTH-1:0]   r_wave_prev;
    logic [HC_W-1:0]         r_hold_cnt;
    logic [RESP_LATENCY-1:0] r_pipe;
    logic [ERR_W-1:0]        r_flags;
    logic [CNT_WIDTH-1:0]    r_cnt;

    ch_state_e               w_state_nxt;
    logic [HC_W-1:0]         w_hold_nxt;
    logic                    w_push;
    logic                    w_sel_chg;
    logic [ERR_W-1:0]        w_raise;
    logic                    w_any;

    assign w_sel_chg = (i_sel != r_sel_prev);
    assign w_any     = |w_raise;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_push      = 1'b0;
        w_raise     = '0;
        case (r_state)
            INIT: begin
                w_state_nxt       = IDLE;
                w_raise[ERR_RST]  = (i_wave != '0);
            end
            IDLE: begin
                if (w_sel_chg) begin
                    w_state_nxt = HOLD;
                    w_hold_nxt  = HOLD_RELOAD;
                    w_push      = 1'b1;
                end
            end
            HOLD: begin
                // A change with the counter already at 0 is a legal fresh change.
                if (w_sel_chg) begin
                    w_raise[ERR_HOLD] = (r_hold_cnt != '0);
                    w_hold_nxt        = HOLD_RELOAD;
                    w_push            = 1'b1;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end
            end
            default: w_state_nxt = INIT;
        endcase
        w_raise[ERR_RESP] = r_pipe[RESP_LATENCY-1] && (i_wave == r_wave_prev);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= INIT;
            r_sel_prev  <= '0;
            r_wave_prev <= '0;
            r_hold_cnt  <= '0;
            r_pipe      <= '0;
            r_flags     <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_prev  <= i_sel;
            r_wave_prev <= i_wave;
            r_hold_cnt  <= w_hold_nxt;
            r_pipe      <= RESP_LATENCY'({r_pipe, w_push});
            // A violation on the clearing edge survives the clear.
            r_flags     <= (i_clear ? '0 : r_flags) | w_raise;
            if (i_clear) begin
                r_cnt <= {{(CNT_WIDTH-1){1'b0}}, w_any};
            end else if (w_any && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_flags = r_flags;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/nco_mc_monitor.sv
// NUM_CH-channel NCO protocol monitor: per-channel checkers plus a registered
// interrupt that is the OR of every sticky flag.
module nco_mc_monitor
    import nco_mon_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SELECT_WIDTH = 3,
    parameter int WAVE_WIDTH   = 8,
    parameter int HOLD_CYCLES  = 32,
    parameter int RESP_LATENCY = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_CH*SELECT_WIDTH-1:0] signal_out,
    input  logic [NUM_CH*WAVE_WIDTH-1:0]   wave_out,
    input  logic                           clear_i,
    output logic [NUM_CH*ERR_W-1:0]        err_flags_o,
    output logic [NUM_CH*CNT_WIDTH-1:0]    err_cnt_o,
    output logic                           irq_o
);

    logic r_irq;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        nco_ch_checker #(
            .SELECT_WIDTH (SELECT_WIDTH),
            .WAVE_WIDTH   (WAVE_WIDTH),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .RESP_LATENCY (RESP_LATENCY),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_chk (
            .clk     (clk),
            .resetn  (resetn),
            .i_sel   (signal_out[gi*SELECT_WIDTH +: SELECT_WIDTH]),
            .i_wave  (wave_out[gi*WAVE_WIDTH +: WAVE_WIDTH]),
            .i_clear (clear_i),
            .o_flags (err_flags_o[gi*ERR_W +: ERR_W]),
            .o_cnt   (err_cnt_o[gi*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |err_flags_o;
        end
    end

    assign irq_o = r_irq;

endmodule

// File: tb/tb_nco_mc_monitor.sv
// Scoreboard bench for nco_mc_monitor: a default 4-channel instance plus a
// 1-channel instance with RESP_LATENCY=3 for the deeper response pipeline.
module tb_nco_mc_monitor;

    localparam int NUM_CH = 4;
    localparam int SW     = 3;
    localparam int WW     = 8;
    localparam int CW     = 8;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 clear;
    logic [NUM_CH*SW-1:0] sel;
    logic [NUM_CH*WW-1:0] wave;
    logic [NUM_CH*3-1:0]  flags;
    logic [NUM_CH*CW-1:0] cnt;
    logic                 irq;
    logic [SW-1:0]        sel3;
    logic [WW-1:0]        wave3;
    logic [2:0]           flags3;
    logic [CW-1:0]        cnt3;
    logic                 irq3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    nco_mc_monitor #(
        .NUM_CH(NUM_CH), .SELECT_WIDTH(SW), .WAVE_WIDTH(WW),
        .HOLD_CYCLES(32), .RESP_LATENCY(1), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .resetn(resetn), .signal_out(sel), .wave_out(wave),
        .clear_i(clear), .err_flags_o(flags), .err_cnt_o(cnt), .irq_o(irq)
    );

    nco_mc_monitor #(
        .NUM_CH(1), .SELECT_WIDTH(SW), .WAVE_WIDTH(WW),
        .HOLD_CYCLES(32), .RESP_LATENCY(3), .CNT_WIDTH(CW)
    ) u_dut3 (
        .clk(clk), .resetn(resetn), .signal_out(sel3), .wave_out(wave3),
        .clear_i(clear), .err_flags_o(flags3), .err_cnt_o(cnt3), .irq_o(irq3)
    );

    always @(posedge clk) begin
        if (resetn) begin
            assert (!$isunknown({sel, wave, sel3, wave3, clear}));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_q.push_back('{tag, v});
    endtask

    task automatic sb_cmp(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", obs, 32'hDEAD_BEEF);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int ch, input int v);
        sel[ch*SW +: SW] = SW'(v);
    endtask

    task automatic set_wave(input int ch, input int v);
        wave[ch*WW +: WW] = WW'(v);
    endtask

    function automatic logic [31:0] fl(input int ch);
        return 32'(flags[ch*3 +: 3]);
    endfunction

    function automatic logic [31:0] ct(input int ch);
        return 32'(cnt[ch*CW +: CW]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        clear  = 1'b0;
        sel    = '0;
        wave   = '0;
        sel3   = '0;
        wave3  = '0;
        set_wave(1, 8'h5A);
        step(2);

        // 1: reset state, then RST flag on ch1 from its nonzero post-reset wave.
        sb_push("rst_flags", 0); sb_push("rst_cnt", 0); sb_push("rst_irq", 0); sb_push("rst_flags3", 0);
        sb_cmp(32'(flags)); sb_cmp(32'(cnt)); sb_cmp(32'(irq)); sb_cmp(32'(flags3));
        resetn = 1'b1;
        sb_push("init_ch1_flag", 1); sb_push("init_ch1_cnt", 1); sb_push("init_irq_lag", 0); sb_push("init_ch0_flag", 0);
        step(1);
        sb_cmp(fl(1)); sb_cmp(ct(1)); sb_cmp(32'(irq)); sb_cmp(fl(0));
        sb_push("init_irq", 1); sb_push("init_ch2_flag", 0); sb_push("init_ch3_flag", 0);
        step(1);
        sb_cmp(32'(irq)); sb_cmp(fl(2)); sb_cmp(fl(3));
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        sb_push("clr_flags", 0); sb_push("clr_cnt", 0); sb_push("clr_irq", 0);
        step(1);
        sb_cmp(32'(flags)); sb_cmp(32'(cnt)); sb_cmp(32'(irq));

        // 2: legal ch0 traffic; next change exactly 32 edges later.
        set_sel(0, 2);
        step(1);
        set_wave(0, 8'h11);
        step(31);
        set_sel(0, 5);
        step(1);
        set_wave(0, 8'h22);
        sb_push("legal_ch0_flag", 0); sb_push("legal_ch0_cnt", 0);
        step(2);
        sb_cmp(fl(0)); sb_cmp(ct(0));

        // 3: ch2 changes 10 edges apart are HOLD violations.
        set_sel(2, 1);
        step(1);
        set_wave(2, 8'h10);
        sb_push("hold_ch2_pre", 0);
        step(9);
        sb_cmp(fl(2));
        set_sel(2, 2);
        sb_push("hold_ch2_flag", 2); sb_push("hold_ch2_cnt1", 1);
        step(1);
        sb_cmp(fl(2)); sb_cmp(ct(2));
        set_wave(2, 8'h20);
        step(9);
        set_sel(2, 3);
        sb_push("hold_ch2_cnt2", 2);
        step(1);
        sb_cmp(ct(2));
        set_wave(2, 8'h30);
        sb_push("hold_ch2_settle", 2);
        step(40);
        sb_cmp(ct(2));

        // 4: RESP with latency 1 on ch3, latency 3 on the second instance.
        set_sel(3, 1);
        sel3 = 3'd1;
        sb_push("resp_ch3_pre", 0); sb_push("resp_l3_t0", 0);
        step(1);
        sb_cmp(fl(3)); sb_cmp(32'(flags3));
        wave3 = 8'h44;
        sb_push("resp_ch3_flag", 4); sb_push("resp_ch3_cnt", 1); sb_push("resp_l3_t1", 0);
        step(1);
        sb_cmp(fl(3)); sb_cmp(ct(3)); sb_cmp(32'(flags3));
        sb_push("resp_l3_t2", 0);
        step(1);
        sb_cmp(32'(flags3));
        sb_push("resp_l3_flag", 4); sb_push("resp_l3_cnt", 1);
        step(1);
        sb_cmp(32'(flags3)); sb_cmp(32'(cnt3));

        // 5: back-to-back ch1 changes saturate the counter; clear loses to a new violation.
        for (int i = 0; i <= 300; i++) begin
            set_sel(1, (i % 2 == 0) ? 1 : 0);
            set_wave(1, i);
            if (i == 254) sb_push("sat_254", 254);
            if (i == 255) sb_push("sat_255", 255);
            if (i == 300) begin
                sb_push("sat_300", 255);
                sb_push("sat_flag", 2);
            end
            step(1);
            if (i == 254 || i == 255) sb_cmp(ct(1));
            if (i == 300) begin
                sb_cmp(ct(1));
                sb_cmp(fl(1));
            end
        end
        set_sel(1, 0);
        set_wave(1, 301);
        clear = 1'b1;
        sb_push("clrwin_flag", 2); sb_push("clrwin_cnt", 1); sb_push("clrwin_ch2_flag", 0); sb_push("clrwin_ch2_cnt", 0);
        step(1);
        clear = 1'b0;
        sb_cmp(fl(1)); sb_cmp(ct(1)); sb_cmp(fl(2)); sb_cmp(ct(2));
        set_wave(1, 302);
        sb_push("clrwin_after", 2);
        step(1);
        sb_cmp(fl(1));

        // 6: asynchronous reset with ch0 in HOLD and a token in flight.
        set_sel(0, 6);
        step(1);
        #2;
        resetn = 1'b0;
        #1;
        sb_push("async_flags", 0); sb_push("async_cnt", 0); sb_push("async_irq", 0);
        sb_push("async_flags3", 0); sb_push("async_cnt3", 0);
        sb_cmp(32'(flags)); sb_cmp(32'(cnt)); sb_cmp(32'(irq));
        sb_cmp(32'(flags3)); sb_cmp(32'(cnt3));
        set_sel(0, 3);
        wave  = '0;
        wave3 = '0;
        step(1);
        resetn = 1'b1;
        sb_push("reinit_flags", 0); sb_push("reinit_flags3", 0);
        step(1);
        sb_cmp(32'(flags)); sb_cmp(32'(flags3));
        sb_push("reinit_later", 0); sb_push("reinit_cnt", 0); sb_push("reinit_irq", 0);
        step(4);
        sb_cmp(32'(flags)); sb_cmp(32'(cnt)); sb_cmp(32'(irq));

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
